// File: rtl/hexdisp_pkg.sv
// Shared types and constants for the hex display scanner: debounce state
// encoding, blank-digit pattern and the active-low 7-segment table.
package hexdisp_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } deb_state_t;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segments, bit 6 = g ... bit 0 = a. Entry 0 is the rightmost.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/hex_display_scanner_if.sv
// Bundles the channel buses, user controls and display outputs of the
// hex display scanner. master = stimulus side, slave = the scanner.
interface hex_display_scanner_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32
);
  localparam int NUM_DIG = DATA_W / 4;
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0][DATA_W-1:0] ch_data;
  logic                          key_next;
  logic                          mode_auto;
  logic                          hold;
  logic [NUM_DIG-1:0][6:0]       hex;
  logic [IDX_W-1:0]              ch_idx;
  logic                          hold_led;

  modport master (
    output ch_data, key_next, mode_auto, hold,
    input  hex, ch_idx, hold_led
  );

  modport slave (
    input  ch_data, key_next, mode_auto, hold,
    output hex, ch_idx, hold_led
  );
endinterface

// File: rtl/hex_display_scanner_hexcoder.sv
// One hex digit to active-low 7-segment pattern, purely combinational.
module hexcoder
  import hexdisp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/hex_display_scanner.sv
// Hex display scanner: selects one of NUM_CH channel buses (manual key
// stepping or timed auto-cycling), latches it into a display register and
// drives NUM_DIG active-low 7-segment digits.
// Optional build macro HEXDISP_BLANK_ZEROS_EN blanks leading zero digits
// (digit 0 is always shown).
// DEB_CYCLES and DWELL_CYCLES are expected to be at least 2.
module hex_display_scanner
  import hexdisp_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 32,
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input logic                   clk,
  input logic                   rst_n,
  hex_display_scanner_if.slave  bus
);
  localparam int NUM_DIG = DATA_W / 4;
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);

  localparam logic [IDX_W-1:0]   LAST_CH    = IDX_W'(NUM_CH - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  logic [1:0] key_sync, mode_sync, hold_sync;
  logic       mode_q;
  logic       key_s, mode_s, hold_s, mode_chg;

  // Two-flop synchronisers for the key and both switches; key resets released.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync  <= 2'b11;
      mode_sync <= 2'b00;
      hold_sync <= 2'b00;
      mode_q    <= 1'b0;
    end else begin
      key_sync  <= {key_sync[0], bus.key_next};
      mode_sync <= {mode_sync[0], bus.mode_auto};
      hold_sync <= {hold_sync[0], bus.hold};
      mode_q    <= mode_sync[1];
    end
  end

  assign key_s    = key_sync[1];
  assign mode_s   = mode_sync[1];
  assign hold_s   = hold_sync[1];
  assign mode_chg = mode_s ^ mode_q;

  deb_state_t       state, state_n;
  logic [DEB_W-1:0] deb_cnt, deb_cnt_n;
  logic             press;

  // Debounce state register and stable-level counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RELEASED;
      deb_cnt <= '0;
    end else begin
      state   <= state_n;
      deb_cnt <= deb_cnt_n;
    end
  end

  // Debounce next state; deb_cnt holds how many consecutive cycles the new
  // level has been seen, and press fires only on the PRESS_WAIT->PRESSED step.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_n   = state;
    deb_cnt_n = deb_cnt;
    press     = 1'b0;
    unique case (state)
      RELEASED: begin
        if (!key_s) begin
          state_n   = PRESS_WAIT;
          deb_cnt_n = DEB_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_n   = RELEASED;
          deb_cnt_n = '0;
        end else if (deb_cnt >= DEB_LAST) begin
          state_n   = PRESSED;
          deb_cnt_n = '0;
          press     = 1'b1;
        end else begin
          deb_cnt_n = deb_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_n   = RELEASE_WAIT;
          deb_cnt_n = DEB_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_n   = PRESSED;
          deb_cnt_n = '0;
        end else if (deb_cnt >= DEB_LAST) begin
          state_n   = RELEASED;
          deb_cnt_n = '0;
        end else begin
          deb_cnt_n = deb_cnt + 1'b1;
        end
      end
      default: state_n = RELEASED;
    endcase
  end

  logic [IDX_W-1:0]   ch_idx_q;
  logic [DWELL_W-1:0] dwell;
  logic               advance;

  // A press and a dwell terminal count landing together still give one step.
  assign advance = !hold_s && (press || (mode_s && (dwell == DWELL_LAST)));

  // Channel index and dwell timer; the timer idles at zero in manual mode and
  // restarts on every advance or mode flip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_idx_q <= '0;
      dwell    <= '0;
    end else begin
      if (advance) begin
        ch_idx_q <= (ch_idx_q == LAST_CH) ? '0 : ch_idx_q + 1'b1;
      end
      if (advance || mode_chg || !mode_s) begin
        dwell <= '0;
      end else if (!hold_s) begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  logic [DATA_W-1:0] disp;

  // Display register follows the selected channel unless frozen by hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp <= '0;
    end else if (!hold_s) begin
      disp <= bus.ch_data[ch_idx_q];
    end
  end

  assign bus.ch_idx   = ch_idx_q;
  assign bus.hold_led = hold_s;

  logic [NUM_DIG-1:0][6:0] seg;

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    hexcoder u_hexcoder (
      .nibble (disp[4*g +: 4]),
      .seg    (seg[g])
    );
  end

`ifdef HEXDISP_BLANK_ZEROS_EN
  // upper_zero[i]: digits i..NUM_DIG-1 are all zero, so digit i is leading.
  logic [NUM_DIG:1] upper_zero;
  assign upper_zero[NUM_DIG] = 1'b1;
  assign bus.hex[0] = seg[0];
  for (genvar g = 1; g < NUM_DIG; g++) begin : g_blank
    assign upper_zero[g] = upper_zero[g+1] && (disp[4*g +: 4] == 4'h0);
    assign bus.hex[g]    = upper_zero[g] ? SEG_BLANK : seg[g];
  end
`else
  assign bus.hex = seg;
`endif

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner: a cycle model built from the
// behavioural rules (level run lengths, dwell timing, hold freeze) is compared
// against the DUT on every falling edge, plus hand-computed literal checks.
module tb_hex_display_scanner;
  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 32;
  localparam int NUM_DIG = 8;
  localparam int DEB     = 4;
  localparam int DWELL   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  hex_display_scanner_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  hex_display_scanner #(
    .NUM_CH       (NUM_CH),
    .DATA_W       (DATA_W),
    .DEB_CYCLES   (DEB),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference digit shapes, index = hex value.
  logic [6:0] seg_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [55:0] expect_hex(input logic [31:0] v);
    logic [55:0] r;
`ifdef HEXDISP_BLANK_ZEROS_EN
    int top_nz = 0;
    for (int d = 0; d < NUM_DIG; d++) if (v[d*4 +: 4] != 4'h0) top_nz = d;
`endif
    for (int d = 0; d < NUM_DIG; d++) begin
      r[d*7 +: 7] = seg_ref[v[d*4 +: 4]];
`ifdef HEXDISP_BLANK_ZEROS_EN
      if (d > top_nz) r[d*7 +: 7] = 7'b1111111;
`endif
    end
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  logic [1:0]  key_pipe, mode_pipe, hold_pipe;
  logic        key_seen, mode_seen, hold_seen, mode_prev, pulse, adv;
  bit          pressed_m;
  int          low_run, high_run, dwell_m, idx_m;
  logic [31:0] disp_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_pipe  = 2'b11;
      mode_pipe = 2'b00;
      hold_pipe = 2'b00;
      mode_prev = 1'b0;
      pressed_m = 1'b0;
      low_run   = 0;
      high_run  = 0;
      dwell_m   = 0;
      idx_m     = 0;
      disp_m    = '0;
    end else begin
      key_seen  = key_pipe[1];
      mode_seen = mode_pipe[1];
      hold_seen = hold_pipe[1];
      key_pipe  = {key_pipe[0], bus.key_next};
      mode_pipe = {mode_pipe[0], bus.mode_auto};
      hold_pipe = {hold_pipe[0], bus.hold};

      if (key_seen) begin high_run++; low_run = 0; end
      else          begin low_run++;  high_run = 0; end
      pulse = 1'b0;
      if (!pressed_m && low_run == DEB) begin
        pressed_m = 1'b1;
        pulse     = 1'b1;
      end else if (pressed_m && high_run == DEB) begin
        pressed_m = 1'b0;
      end

      if (!hold_seen) disp_m = bus.ch_data[idx_m];
      adv = !hold_seen && (pulse || (mode_seen && dwell_m == DWELL - 1));
      if (adv) idx_m = (idx_m + 1) % NUM_CH;
      if (adv || !mode_seen || mode_seen != mode_prev) dwell_m = 0;
      else if (!hold_seen) dwell_m++;
      mode_prev = mode_seen;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("model_ch_idx", 64'(bus.ch_idx), 64'(idx_m));
    check("model_hex", 64'(bus.hex), 64'(expect_hex(disp_m)));
    check("model_hold_led", 64'(bus.hold_led), 64'(hold_pipe[1]));
  end

  // ---------------- stimulus helpers ----------------
  task automatic press_key(input int low_cycles, input int high_cycles);
    @(posedge clk); #1 bus.key_next = 1'b0;
    repeat (low_cycles) @(posedge clk);
    #1 bus.key_next = 1'b1;
    repeat (high_cycles) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Returns cycles until ch_idx changes, 0 if it never does within the bound.
  task automatic wait_change(output int n);
    logic [1:0] start;
    start = bus.ch_idx;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.ch_idx != start) begin
        n = i;
        break;
      end
    end
  endtask

  localparam logic [55:0] HEX_12345678 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                         7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};
  localparam logic [55:0] HEX_9ABCDEF0 = {7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110,
                                         7'b0100001, 7'b0000110, 7'b0001110, 7'b1000000};
  localparam logic [55:0] HEX_DEADBEEF = {7'b0100001, 7'b0000110, 7'b0001000, 7'b0100001,
                                         7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110};
  localparam logic [55:0] HEX_ZERO     = {8{7'b1000000}};
`ifdef HEXDISP_BLANK_ZEROS_EN
  localparam logic [55:0] HEX_A0 = {{6{7'b1111111}}, 7'b0001000, 7'b1000000};
  localparam logic [55:0] HEX_00 = {{7{7'b1111111}}, 7'b1000000};
`else
  localparam logic [55:0] HEX_A0 = {{6{7'b1000000}}, 7'b0001000, 7'b1000000};
  localparam logic [55:0] HEX_00 = {8{7'b1000000}};
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.key_next  = 1'b1;
    bus.mode_auto = 1'b0;
    bus.hold      = 1'b0;
    bus.ch_data[0] = 32'h12345678;
    bus.ch_data[1] = 32'h9ABCDEF0;
    bus.ch_data[2] = 32'h0BADF00D;
    bus.ch_data[3] = 32'h00C0FFEE;

    // Reset state.
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ch_idx", 64'(bus.ch_idx), 64'd0);
    check("rst_hex", 64'(bus.hex), 64'(HEX_ZERO));
    check("rst_hold_led", 64'(bus.hold_led), 64'd0);

    // Channel 0 appears one cycle after reset release.
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("hex_12345678", 64'(bus.hex), 64'(HEX_12345678));
    check("ch_idx_after_rst", 64'(bus.ch_idx), 64'd0);

    // Short glitch is ignored; long press steps once.
    press_key(3, 10);
    check("short_press_no_step", 64'(bus.ch_idx), 64'd0);
    press_key(10, 10);
    check("long_press_one_step", 64'(bus.ch_idx), 64'd1);

    // Four clean presses from reset: 1,2,3,0.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      press_key(6, 8);
      check("manual_step", 64'(bus.ch_idx), 64'(i % NUM_CH));
    end

    // Reset while the key is held: a full debounce is needed afterwards.
    @(posedge clk); #1 bus.key_next = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("midpress_rst_no_early_pulse", 64'(bus.ch_idx), 64'd0);
    @(posedge clk); @(negedge clk);
    check("midpress_rst_full_debounce", 64'(bus.ch_idx), 64'd1);
    @(posedge clk); #1 bus.key_next = 1'b1;
    repeat (8) @(posedge clk);

    // Auto mode: first step, then a full dwell period of 8.
    #1 bus.mode_auto = 1'b1;
    wait_change(n);
    check("auto_first_step_seen", 64'(n != 0), 64'd1);
    check("auto_first_idx", 64'(bus.ch_idx), 64'd2);
    wait_change(n);
    check("auto_dwell_period", 64'(n), 64'd8);
    check("auto_second_idx", 64'(bus.ch_idx), 64'd3);

    // Press pulse timed onto the next terminal-count edge.
    @(posedge clk); @(posedge clk);
    #1 bus.key_next = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("auto_before_tc", 64'(bus.ch_idx), 64'd3);
    @(posedge clk); @(negedge clk);
    check("auto_press_on_tc_single", 64'(bus.ch_idx), 64'd0);
    @(posedge clk); #1 bus.key_next = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("auto_dwell_restarted", 64'(bus.ch_idx), 64'd0);
    @(posedge clk); @(negedge clk);
    check("auto_next_step", 64'(bus.ch_idx), 64'd1);

    // Back to manual, then hold.
    @(posedge clk); #1 bus.mode_auto = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.hold = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hold_led_on", 64'(bus.hold_led), 64'd1);
    @(posedge clk); #1 bus.ch_data[1] = 32'hDEADBEEF;
    press_key(6, 8);
    @(negedge clk);
    check("hold_idx_frozen", 64'(bus.ch_idx), 64'd1);
    check("hold_hex_frozen", 64'(bus.hex), 64'(HEX_9ABCDEF0));
    @(posedge clk); #1 bus.hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("unhold_deadbeef", 64'(bus.hex), 64'(HEX_DEADBEEF));
    check("hold_led_off", 64'(bus.hold_led), 64'd0);
    check("unhold_idx", 64'(bus.ch_idx), 64'd1);

    // Leading-zero handling.
    @(posedge clk); #1 bus.ch_data[1] = 32'h000000A0;
    @(posedge clk); @(negedge clk);
    check("hex_000000a0", 64'(bus.hex), 64'(HEX_A0));
    @(posedge clk); #1 bus.ch_data[1] = 32'h00000000;
    @(posedge clk); @(negedge clk);
    check("hex_00000000", 64'(bus.hex), 64'(HEX_00));

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 Parameter NUM_CH, default 4, number of selectable 32-bit channels (2..16).
REQ-002 Parameter DATA_W, default 32, channel width; multiple of 4; NUM_DIG = DATA_W/4 digits.
REQ-003 Parameter DEB_CYCLES, default 1_000_000, clock cycles a key level must be stable before acceptance.
REQ-004 Parameter DWELL_CYCLES, default 50_000_000, clock cycles per channel in auto mode.
REQ-005 clk  in  1  single system clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 ch_data  in  NUM_CH x DATA_W packed array  channel buses; element 0 = instruction, 1 = rd1, 2 = rd2, 3 = result by convention.
REQ-008 key_next  in  1  raw active-low pushbutton, asynchronous to clk.
REQ-009 mode_auto  in  1  switch; 1 = auto-cycle channels, 0 = manual.
REQ-010 hold  in  1  switch; 1 = freeze channel index and displayed value.
REQ-011 hex  out  NUM_DIG x 7  active-low segment patterns, digit 0 = bits [3:0].
REQ-012 ch_idx  out  clog2(NUM_CH)  currently selected channel.
REQ-013 hold_led  out  1  registered copy of hold.

Function
REQ-014 key_next SHALL pass a 2-flop synchroniser before any other use.
REQ-015 Debounce FSM states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT; RELEASED->PRESS_WAIT on sync key low; PRESS_WAIT->PRESSED after DEB_CYCLES consecutive low cycles, else back to RELEASED on any high; PRESSED->RELEASE_WAIT on high; RELEASE_WAIT->RELEASED after DEB_CYCLES consecutive high cycles, else back to PRESSED.
REQ-016 A one-cycle press pulse SHALL fire on the PRESS_WAIT->PRESSED transition only; holding the key gives exactly one pulse.
REQ-017 Manual mode: press pulse advances ch_idx by 1, wrapping NUM_CH-1 -> 0.
REQ-018 Auto mode: dwell counter counts 0..DWELL_CYCLES-1; at terminal count ch_idx advances with wrap and counter returns to 0.
REQ-019 Auto mode press pulse SHALL also advance and clear the dwell counter; press and terminal count in the same cycle give exactly one advance.
REQ-020 Any change of mode_auto (sync'd) SHALL clear the dwell counter.
REQ-021 hold=1: ch_idx, dwell counter and display register frozen; press pulses discarded (FSM still runs).
REQ-022 Display register loads ch_data[ch_idx] every cycle when hold=0; hex reflects new ch_idx or data exactly 1 cycle after it changes (registered, no combinational path ch_data->hex beyond the decoder).
REQ-023 Each digit decoded 0-F to standard active-low 7-segment patterns (0 = 7'b1000000, F = 7'b0001110).

Reset
REQ-024 rst_n low SHALL immediately force: ch_idx 0, display register 0 (all digits show "0"), dwell counter 0, debounce FSM RELEASED, counters 0, hold_led 0, synchronisers 1 (key released).
REQ-025 Reset mid-press SHALL produce no press pulse after deassertion until a full new debounce completes.

Configuration
REQ-026 Macro HEXDISP_BLANK_ZEROS_EN defined: leading zero digits (from digit NUM_DIG-1 downward, never digit 0) output 7'b1111111; undefined: all digits always decoded.

Structure
REQ-027 Package hexdisp_pkg SHALL hold the debounce state enum, SEG_BLANK constant and the 16-entry segment table.
REQ-028 One sub-module, hexcoder (4-bit to 7-segment), instantiated NUM_DIG times via generate.

Verification
REQ-029 Reset, ch_data[0]=32'h12345678 -> after 1 cycle hex = 1,2,3,4,5,6,7,8 patterns, ch_idx=0.
REQ-030 DEB_CYCLES=4, key low 3 cycles then high -> no advance; low 10 cycles -> exactly one advance to ch_idx=1.
REQ-031 Manual, NUM_CH=4, 4 clean presses -> ch_idx 1,2,3,0.
REQ-032 Auto, DWELL_CYCLES=8 -> ch_idx increments every 8 cycles; press on terminal-count cycle -> single increment.
REQ-033 hold=1, change ch_data[ch_idx] to 32'hDEADBEEF and press key -> hex and ch_idx unchanged; hold=0 -> DEADBEEF shown next cycle.
REQ-034 With HEXDISP_BLANK_ZEROS_EN, value 32'h000000A0 -> digits 7..2 blank, digit1 "A", digit0 "0"; value 0 -> only digit0 "0".
